gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt: RTL and testbench
======================================================

// Module: gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt
// PURPOSE
//  Receive end of a buffered single-bit net (a buf-driven signal crossing in from another clock or
//  an off-block source). Synchronizes input I into the CLK domain and rejects pulses shorter than
//  FILT_CYC cycles. Drives a clean level Z plus single-cycle edge strobes and a saturating glitch count.
//  Sits at the sink of long buf trees and pad inputs, ahead of any logic that consumes them.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flop count; legal range >=2
//  FILT_CYC     4   consecutive synced cycles a new level must persist before Z follows; legal >=1
//  RST_VAL      0   reset level of the sync chain and Z
//  GCNT_W       8   width of the glitch counter
// PORTS
//  CLK          in   1        clock; all state updates on the rising edge
//  RST          in   1        asynchronous, active-high reset
//  VDD, VSS     inout 1       present only under USE_POWER_PINS
//  I            in   1        raw input; asynchronous to CLK
//  CLR          in   1        synchronous clear of GLITCH_CNT
//  Z            out  1        filtered level
//  RISE         out  1        one-cycle strobe; high in the cycle Z goes 0->1
//  FALL         out  1        one-cycle strobe; high in the cycle Z goes 1->0
//  BUSY         out  1        a candidate level change is being qualified (QUAL state)
//  GLITCH_CNT   out  GCNT_W   count of rejected pulses; saturates
// BEHAVIOUR
//  Reset (RST=1, async): sync chain=RST_VAL, Z=RST_VAL, RISE=FALL=0, BUSY=0, cnt=0, GLITCH_CNT=0,
//   state=STABLE. Release is synchronous to the next CLK edge; no edge strobe fires on release.
//  Synchronizer: S = output of the last of SYNC_STAGES flops sampling I. Only S feeds the filter.
//  Counter cnt has width $clog2(FILT_CYC+1).
//  FSM (evaluated every edge, using S):
//   STABLE: S==Z -> stay, cnt=0. S!=Z and FILT_CYC==1 -> commit. S!=Z otherwise -> QUAL, cnt=1.
//   QUAL:   S==Z -> STABLE, cnt=0, glitch event. S!=Z and cnt==FILT_CYC-1 -> commit.
//           S!=Z otherwise -> cnt=cnt+1.
//   commit: Z<=S, cnt=0, state=STABLE; RISE<=S or FALL<=~S for exactly one cycle.
//  Latency: I toggles with setup met before edge 1 and then holds -> Z, RISE/FALL update at edge
//   SYNC_STAGES+FILT_CYC. Pulses on S shorter than FILT_CYC cycles never reach Z.
//  BUSY is a registered output, high exactly while state==QUAL.
//  RISE/FALL are registered and mutually exclusive; never both high.
//  GLITCH_CNT: +1 on each glitch event; holds at 2^GCNT_W-1. If CLR and a glitch event occur in
//   the same cycle, CLR wins and the result is 0.
//  Reset mid-QUAL: the qualification is discarded, Z returns to RST_VAL, and no strobe fires.
//  Metastability is bounded by SYNC_STAGES only. No X may propagate from the first sync flop to
//   Z in simulation once RST has been applied.
// TESTING
//  1 Reset: RST=1 with I=1 and RST_VAL=0 -> Z=0, strobes=0, GLITCH_CNT=0; release -> no strobe
//    fires; Z=1 at edge 2+4=6 with RISE=1 for one cycle.
//  2 Latency: defaults, I 0->1 held -> Z rises and RISE pulses at edge 6 after the change.
//    I 1->0 held -> FALL pulses at edge 6 after the change.
//  3 Glitch: I high for 3 cycles then low -> Z stays 0, no RISE, BUSY high for 3 cycles,
//    GLITCH_CNT 0->1. Repeat 300 times with GCNT_W=8 -> GLITCH_CNT saturates at 255.
//  4 CLR collision: CLR=1 in the same cycle as a glitch event -> GLITCH_CNT=0 next cycle, not 1.
//  5 FILT_CYC=1, SYNC_STAGES=3: 1-cycle-wide S pulse -> passes to Z at edge 4; RISE then FALL
//    follow on consecutive edges.
//  6 Async reset mid-QUAL: assert RST between edges while BUSY=1 -> Z=RST_VAL and BUSY=0
//    immediately, before the next CLK edge.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt.sv
// gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt: synchronize an async net, reject short pulses, emit level/edges/glitch count
module gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYC    = 4,
  parameter logic RST_VAL     = 1'b0,
  parameter int   GCNT_W      = 8
) (
`ifdef USE_POWER_PINS
  inout  wire               VDD,
  inout  wire               VSS,
`endif
  input  logic              CLK,
  input  logic              RST,
  input  logic              I,
  input  logic              CLR,
  output logic              Z,
  output logic              RISE,
  output logic              FALL,
  output logic              BUSY,
  output logic [GCNT_W-1:0] GLITCH_CNT
);
  localparam int CW = $clog2(FILT_CYC + 1);
  typedef enum logic {STABLE = 1'b0, QUAL = 1'b1} state_t;
  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   r_z, r_rise, r_fall;
  logic [GCNT_W-1:0]      r_gcnt;
  logic                   w_s, w_diff, w_commit, w_glitch;
  // synchronizer chain; only its last stage is ever seen by the filter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= {SYNC_STAGES{RST_VAL}};
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], I};
  end
  assign w_s = r_sync[SYNC_STAGES-1];
  // state, qualification counter, filtered level, strobes and glitch count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_z     <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_z     <= w_commit ? w_s : r_z;
      r_rise  <= w_commit & w_s;
      r_fall  <= w_commit & ~w_s;
      r_gcnt  <= CLR ? '0 : (w_glitch && !(&r_gcnt)) ? r_gcnt + GCNT_W'(1) : r_gcnt;
    end
  end
  // a level change commits once it has been seen FILT_CYC consecutive edges; a relapse is a glitch
  always_comb begin
    w_diff      = w_s != r_z;
    w_commit    = w_diff && ((FILT_CYC == 1) || (r_state == QUAL && r_cnt == CW'(FILT_CYC - 1)));
    w_glitch    = (r_state == QUAL) && !w_diff;
    w_state_nxt = (w_diff && !w_commit) ? QUAL : STABLE;
    w_cnt_nxt   = (w_diff && !w_commit) ? r_cnt + CW'(1) : '0;
  end
  // outputs come straight from flops
  always_comb begin
    Z          = r_z;
    RISE       = r_rise;
    FALL       = r_fall;
    BUSY       = r_state == QUAL;
    GLITCH_CNT = r_gcnt;
  end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt.sv
// tb_gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt: directed bench with a sample-window reference model
module tb_gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt;
  localparam int SYNC = 2;
  localparam int F    = 4;
  logic       CLK = 1'b0, RST = 1'b0, I = 1'b1, CLR = 1'b0, I2 = 1'b0;
  logic       Z, RISE, FALL, BUSY;
  logic [7:0] GC;
  logic       Z2, R2, F2, B2;
  logic [7:0] GC2;
  int n_cmp = 0, n_err = 0;
  int n_busy = 0, n_rise = 0;
  bit ih[$];
  bit sh[$];
  bit m_s, m_commit, m_glitch;
  bit m_z = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
  int m_gcnt = 0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt #(.SYNC_STAGES(SYNC), .FILT_CYC(F), .RST_VAL(1'b0), .GCNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .I(I), .CLR(CLR), .Z(Z), .RISE(RISE), .FALL(FALL), .BUSY(BUSY), .GLITCH_CNT(GC));

  gf180mcu_fd_sc_mcu9t5v0_buf_rx_filt #(.SYNC_STAGES(3), .FILT_CYC(1), .RST_VAL(1'b0), .GCNT_W(8)) dut2 (
    .CLK(CLK), .RST(RST), .I(I2), .CLR(1'b0), .Z(Z2), .RISE(R2), .FALL(F2), .BUSY(B2), .GLITCH_CNT(GC2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: Z takes the synced value once the last F synced samples all differ from Z;
  // a glitch is a synced sample equal to Z right after one that differed without committing.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ih.delete();
      sh.delete();
      repeat (SYNC + 1) ih.push_back(1'b0);
      repeat (F + 1) sh.push_back(1'b0);
      m_z = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_gcnt = 0;
    end else begin
      ih.push_front(I);
      void'(ih.pop_back());
      m_s = ih[SYNC];
      sh.push_front(m_s);
      void'(sh.pop_back());
      m_commit = 1'b1;
      for (int i = 0; i < F; i++) if (sh[i] == m_z) m_commit = 1'b0;
      m_glitch = (sh[0] == m_z) && (sh[1] != m_z);
      m_rise = m_commit && m_s;
      m_fall = m_commit && !m_s;
      if (m_commit) m_z = m_s;
      m_busy = m_s != m_z;
      if (CLR) m_gcnt = 0;
      else if (m_glitch && m_gcnt < 255) m_gcnt = m_gcnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check("z", Z, m_z);
      check("rise", RISE, m_rise);
      check("fall", FALL, m_fall);
      check("busy", BUSY, m_busy);
      check("gcnt", GC, m_gcnt);
    end
  end

  always @(negedge CLK) begin
    if (BUSY === 1'b1) n_busy++;
    if (RISE === 1'b1) n_rise++;
  end

  task automatic lat(input logic v, input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    I = v;
    while (n < 20) begin
      @(posedge CLK);
      #1;
      n++;
      if (v ? RISE : FALL) break;
    end
    check(nm, n, 6);
  endtask

  task automatic glitch(input int nh, input bit clr_hit);
    @(negedge CLK);
    I = 1'b1;
    repeat (nh) @(negedge CLK);
    I = 1'b0;
    repeat (2) @(negedge CLK);
    if (clr_hit) CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #1 RST = 1'b1;
    I = 1'b1;
    #10;
    check("rst_z", Z, 0);
    check("rst_rise", RISE, 0);
    check("rst_fall", FALL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_gcnt", GC, 0);
    check("rst_z2", Z2, 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLK);
      #1;
      check("rel_z", Z, k >= 6);
      check("rel_rise", RISE, k == 6);
    end
    lat(1'b0, "lat_fall");
    lat(1'b1, "lat_rise");
    lat(1'b0, "lat_fall2");
    n_busy = 0;
    n_rise = 0;
    glitch(3, 1'b0);
    check("g_busy", n_busy, 3);
    check("g_rise", n_rise, 0);
    check("g_z", Z, 0);
    check("g_cnt", GC, 1);
    repeat (300) glitch(3, 1'b0);
    check("sat", GC, 255);
    glitch(3, 1'b1);
    check("clr_hit", GC, 0);
    glitch(3, 1'b0);
    check("g_after", GC, 1);
    glitch(3, 1'b1);
    check("clr_hit2", GC, 0);
    @(negedge CLK);
    I2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK);
      #1;
      if (k == 1) I2 = 1'b0;
      check("f1_z", Z2, k == 4);
      check("f1_rise", R2, k == 4);
      check("f1_fall", F2, k == 5);
      check("f1_busy", B2, 0);
    end
    lat(1'b1, "lat_rise2");
    @(negedge CLK);
    I = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    check("q_busy", BUSY, 1);
    check("q_z", Z, 1);
    RST = 1'b1;
    #1;
    check("ar_z", Z, 0);
    check("ar_busy", BUSY, 0);
    check("ar_fall", FALL, 0);
    check("ar_rise", RISE, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("post_z", Z, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
